// File: rtl/sensor_debounce_bank.sv
// Per-channel synchronizer plus enabled-sample debounce counter.
// Produces a registered level and one-cycle rise/fall/changed pulses.
module sensor_debounce_bank #(
    parameter int                  CHANNELS    = 4,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  DEBOUNCE    = 4,
    parameter logic [CHANNELS-1:0] RESET_VAL   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                changed
);

    localparam int            CW   = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
    logic [CW-1:0]       cnt_r  [CHANNELS];
    logic [CW-1:0]       cnt_nxt[CHANNELS];
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] toggle;

    assign s = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= RESET_VAL;
            end
        end else begin
            sync_r[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Toggle on the DEBOUNCE-th consecutive enabled mismatch sample.
    always_comb begin
        toggle = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_nxt[ch] = cnt_r[ch];
            if (en) begin
                if (s[ch] == q[ch]) begin
                    cnt_nxt[ch] = '0;
                end else if (cnt_r[ch] == LAST) begin
                    toggle[ch]  = 1'b1;
                    cnt_nxt[ch] = '0;
                end else begin
                    cnt_nxt[ch] = cnt_r[ch] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= RESET_VAL;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_r[ch] <= '0;
            end
        end else begin
            q       <= q ^ toggle;
            rise    <= toggle & ~q;
            fall    <= toggle & q;
            changed <= |toggle;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_r[ch] <= cnt_nxt[ch];
            end
        end
    end

endmodule

// File: tb/tb_sensor_debounce_bank.sv
// Directed bench for sensor_debounce_bank: vector table plus
// hand-written reset, enable-gating, preset and DEBOUNCE=1 sequences.
module tb_sensor_debounce_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic [3:0] din = 4'b0000;
    logic [3:0] din_b = 4'b1010;
    logic [0:0] din_c = 1'b0;

    logic [3:0] q, rise, fall;
    logic       changed;
    logic [3:0] q_b, rise_b, fall_b;
    logic       changed_b;
    logic [0:0] q_c, rise_c, fall_c;
    logic       changed_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sensor_debounce_bank dut (
        .clk(clk), .reset(reset), .en(en), .din(din),
        .q(q), .rise(rise), .fall(fall), .changed(changed)
    );

    sensor_debounce_bank #(.RESET_VAL(4'b1010)) dut_b (
        .clk(clk), .reset(reset), .en(en), .din(din_b),
        .q(q_b), .rise(rise_b), .fall(fall_b), .changed(changed_b)
    );

    sensor_debounce_bank #(
        .CHANNELS(1), .SYNC_STAGES(3), .DEBOUNCE(1), .RESET_VAL(1'b0)
    ) dut_c (
        .clk(clk), .reset(reset), .en(en), .din(din_c),
        .q(q_c), .rise(rise_c), .fall(fall_c), .changed(changed_c)
    );

    typedef struct {
        logic [3:0] din;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       ch;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input logic [3:0] d,
                                input logic [3:0] eq, input logic [3:0] er,
                                input logic [3:0] ef, input logic ec);
        vec_t v;
        v.din  = d;
        v.q    = eq;
        v.rise = er;
        v.fall = ef;
        v.ch   = ec;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst q", q, 4'b0000);
        chk("rst rise", rise, 4'b0000);
        chk("rst fall", fall, 4'b0000);
        chk("rst changed", changed, 1'b0);
        chk("rst q_b", q_b, 4'b1010);
        chk("rst q_c", q_c, 1'b0);
        @(negedge clk) reset = 1'b1;

        // stable rise/fall, short glitch, then full-length change
        add(5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        add(2, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(5, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(3, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(5, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b1);
        add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0);

        foreach (tbl[i]) begin
            din = tbl[i].din;
            en  = 1'b1;
            step();
            chk($sformatf("tbl%0d q", i), q, tbl[i].q);
            chk($sformatf("tbl%0d rise", i), rise, tbl[i].rise);
            chk($sformatf("tbl%0d fall", i), fall, tbl[i].fall);
            chk($sformatf("tbl%0d changed", i), changed, tbl[i].ch);
        end

        // reset entry from q=0010 gives no pulse
        reset = 1'b0;
        #1;
        chk("rstin q", q, 4'b0000);
        chk("rstin fall", fall, 4'b0000);
        chk("rstin changed", changed, 1'b0);

        // reset mid-count discards the partial count
        din = 4'b1000;
        @(negedge clk) reset = 1'b1;
        repeat (4) step();
        chk("mid q", q, 4'b0000);
        reset = 1'b0;
        #1;
        chk("mid rst q", q, 4'b0000);
        chk("mid rst changed", changed, 1'b0);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("rel%0d q", k), q, (k == 6) ? 4'b1000 : 4'b0000);
            chk($sformatf("rel%0d rise", k), rise,
                (k == 6) ? 4'b1000 : 4'b0000);
            chk($sformatf("rel%0d changed", k), changed, k == 6);
        end

        // enable gating: only odd edges sample
        reset = 1'b0;
        din = 4'b0100;
        @(negedge clk) reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            en = (k % 2 == 1);
            step();
            chk($sformatf("en%0d q", k), q, (k >= 9) ? 4'b0100 : 4'b0000);
            chk($sformatf("en%0d rise", k), rise,
                (k == 9) ? 4'b0100 : 4'b0000);
        end

        // preset reset value, then all four bits flip together;
        // DEBOUNCE=1 channel follows its sync output at once
        en = 1'b1;
        chk("pre q_b", q_b, 4'b1010);
        chk("pre changed_b", changed_b, 1'b0);
        din_b = 4'b0101;
        din_c = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("b%0d q", k), q_b, (k == 6) ? 4'b0101 : 4'b1010);
            chk($sformatf("b%0d rise", k), rise_b,
                (k == 6) ? 4'b0101 : 4'b0000);
            chk($sformatf("b%0d fall", k), fall_b,
                (k == 6) ? 4'b1010 : 4'b0000);
            chk($sformatf("b%0d changed", k), changed_b, k == 6);
            chk($sformatf("c%0d q", k), q_c, k >= 4);
            chk($sformatf("c%0d rise", k), rise_c, k == 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_debounce_bank.md
SENSOR_DEBOUNCE_BANK -- requirements
Module: sensor_debounce_bank

Interface
- REQ-001 The block SHALL expose parameter CHANNELS, default 4, giving the number of independent input channels (range 1..32).
- REQ-002 The block SHALL expose parameter SYNC_STAGES, default 2, giving the synchronizer flop depth per channel (range 2..4).
- REQ-003 The block SHALL expose parameter DEBOUNCE, default 4, giving the consecutive enabled samples needed to accept a change (range 1..65535).
- REQ-004 The block SHALL expose parameter RESET_VAL, default all-zero, CHANNELS bits wide, giving the reset level of every channel.
- REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
- REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
- REQ-007 The block SHALL have port en, input, 1 bit: sample enable for the debounce counters.
- REQ-008 The block SHALL have port din, input, CHANNELS bits: raw asynchronous sensor inputs.
- REQ-009 The block SHALL have port q, output, CHANNELS bits: debounced, registered level per channel.
- REQ-010 The block SHALL have port rise, output, CHANNELS bits: one-cycle pulse per channel on a q 0->1 transition.
- REQ-011 The block SHALL have port fall, output, CHANNELS bits: one-cycle pulse per channel on a q 1->0 transition.
- REQ-012 The block SHALL have port changed, output, 1 bit: OR of rise and fall across all channels, registered.

Function
- REQ-013 Each channel SHALL pass din through a SYNC_STAGES-deep flop chain; the last stage is "s".
- REQ-014 The synchronizer chain SHALL run every clk edge, regardless of en.
- REQ-015 Each channel SHALL own a counter of width clog2(DEBOUNCE+1); it SHALL never wrap or saturate past DEBOUNCE.
- REQ-016 On an edge with en=1 and s==q, the channel counter SHALL clear to 0.
- REQ-017 On an edge with en=1, s!=q and counter==DEBOUNCE-1, q SHALL toggle and the counter SHALL clear to 0 on that same edge.
- REQ-018 On an edge with en=1, s!=q and counter<DEBOUNCE-1, the counter SHALL increment by 1.
- REQ-019 On an edge with en=0, counter and q SHALL hold; a mismatch sample with en=0 SHALL neither count nor clear.
- REQ-020 With DEBOUNCE=1, q SHALL follow s on the first enabled edge after a mismatch.
- REQ-021 With en held at 1, a stable din change SHALL appear on q exactly SYNC_STAGES+DEBOUNCE rising edges after the first edge that samples it.
- REQ-022 rise[i] and fall[i] SHALL be registered and asserted for exactly the one cycle following the edge on which q[i] toggled; they SHALL never both be high.
- REQ-023 changed SHALL assert in the same cycle as any rise or fall bit.
- REQ-024 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each debounce and pulse in parallel.
- REQ-025 A din pulse shorter than DEBOUNCE enabled samples (after sync) SHALL produce no q change and no pulse.

Reset
- REQ-026 While reset=0, all synchronizer stages and q SHALL equal RESET_VAL, all counters SHALL be 0, and rise, fall and changed SHALL be 0, asynchronously.
- REQ-027 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be generated by reset entry or release.
- REQ-028 After reset release, the first edge SHALL behave as a normal sampling edge.

Verification (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE=4, en=1 unless stated)
- REQ-029 Drive din=4'b0001, held from edge 0 -> q[0]=1 after edge 6, rise=4'b0001 for one cycle, changed=1 for that same cycle, other bits 0.
- REQ-030 Drive din[1]=1 for 3 cycles, then 0 -> q stays 4'b0000 and no rise/fall/changed pulse ever occurs.
- REQ-031 Drive din[2]=1 held, with en toggling 1,0,1,0,... -> q[2] rises only after 4 enabled mismatch samples, and holds during en=0 edges.
- REQ-032 Drive din[3]=1 held, then reset=0 after 4 edges (count=2), then release -> q=RESET_VAL with no pulse; the full 6-edge latency restarts from release.
- REQ-033 Set RESET_VAL=4'b1010 and din=4'b1010 from reset -> q=4'b1010 with no pulses; then din=4'b0101 -> all four bits toggle on the same edge, rise=4'b0101, fall=4'b1010.
